phy_rx_deser: RTL and testbench

PHY_RX_DESER -- requirements
Module: phy_rx_deser

---
 rtl/phy_rx_pkg.sv | 19 +
 rtl/phy_rx_shift.sv | 36 +++
 rtl/phy_rx_deser.sv | 170 +++++++++++++++++
 tb/tb_phy_rx_deser.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// Shared constants and types for the PHY receive deserializer.
package phy_rx_pkg;

    localparam logic [7:0] COM_DEFAULT  = 8'hBC;
    localparam logic [7:0] IDLE_DEFAULT = 8'h7C;
    localparam int         NUM_LANES    = 4;

    // Commas seen back-to-back (including the first hunt hit) before data is trusted.
    localparam logic [2:0] LOCK_COMMAS  = 3'd4;
    // slip_cnt value at which one more off-boundary comma drops the lock.
    localparam logic [1:0] SLIP_LAST    = 2'd2;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/phy_rx_shift.sv
// Serial shift register and byte-boundary bit counter.
// rx_byte is the byte as it will look after the current edge, so the
// framer can act on a byte at the same edge that samples its last bit.
module phy_rx_shift
    import phy_rx_pkg::*;
(
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       in_serial,
    input  logic       realign,
    output logic [7:0] rx_byte,
    output logic       boundary
);

    logic [7:0] shift_q;
    logic [2:0] bit_cnt;

    assign rx_byte  = {shift_q[6:0], in_serial};
    assign boundary = (bit_cnt == 3'd7);

    // Shift one bit in per clock; realign restarts the byte count at the comma.
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else begin
            shift_q <= rx_byte;
            if (realign) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/phy_rx_deser.sv
// PHY receive deserializer: comma hunt, lock, and round-robin lane unpacking.
// Optional saturating error counter enabled by defining PHY_RX_ERRCNT_EN.
module phy_rx_deser
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM  = COM_DEFAULT,
    parameter logic [7:0] IDLE = IDLE_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       in_serial,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       active
`ifdef PHY_RX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    logic [7:0] rx_byte;
    logic       boundary;
    logic       realign;
    logic       com_hit;
    logic       idle_hit;

    rx_state_t            state, state_nxt;
    logic [2:0]           com_cnt, com_cnt_nxt;
    logic [1:0]           lane_ptr, lane_ptr_nxt;
    logic [1:0]           slip_cnt, slip_cnt_nxt;
    logic [7:0]           lane_q   [NUM_LANES];
    logic [7:0]           lane_nxt [NUM_LANES];
    logic [NUM_LANES-1:0] valid_q, valid_nxt;

    phy_rx_shift u_shift (
        .clk_32f   (clk_32f),
        .rst       (rst),
        .in_serial (in_serial),
        .realign   (realign),
        .rx_byte   (rx_byte),
        .boundary  (boundary)
    );

    assign com_hit  = (rx_byte == COM);
    assign idle_hit = (rx_byte == IDLE);

    // Next-state, lane update and strobe decode for the hunt/lock/active framer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_nxt    = state;
        com_cnt_nxt  = com_cnt;
        lane_ptr_nxt = lane_ptr;
        slip_cnt_nxt = slip_cnt;
        lane_nxt     = lane_q;
        valid_nxt    = '0;
        realign      = 1'b0;

        unique case (state)
            HUNT: begin
                if (com_hit) begin
                    state_nxt   = LOCKING;
                    com_cnt_nxt = 3'd1;
                    realign     = 1'b1;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (com_hit) begin
                        com_cnt_nxt = com_cnt + 3'd1;
                        if (com_cnt_nxt == LOCK_COMMAS) begin
                            state_nxt    = ACTIVE;
                            com_cnt_nxt  = '0;
                            lane_ptr_nxt = '0;
                            slip_cnt_nxt = '0;
                        end
                    end else begin
                        state_nxt   = HUNT;
                        com_cnt_nxt = '0;
                    end
                end
            end
            ACTIVE: begin
                // Boundary handling wins; an off-boundary comma can only occur mid-byte.
                if (boundary) begin
                    if (com_hit) begin
                        lane_ptr_nxt = '0;
                        slip_cnt_nxt = '0;
                    end else if (idle_hit) begin
                        lane_ptr_nxt = lane_ptr + 2'd1;
                    end else begin
                        lane_nxt[lane_ptr]  = rx_byte;
                        valid_nxt[lane_ptr] = 1'b1;
                        lane_ptr_nxt        = lane_ptr + 2'd1;
                    end
                end else if (com_hit) begin
                    if (slip_cnt == SLIP_LAST) begin
                        state_nxt    = HUNT;
                        slip_cnt_nxt = '0;
                        lane_ptr_nxt = '0;
                    end else begin
                        slip_cnt_nxt = slip_cnt + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // Framer state and all registered outputs.
    always_ff @(posedge clk_32f) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state    <= HUNT;
            com_cnt  <= '0;
            lane_ptr <= '0;
            slip_cnt <= '0;
            valid_q  <= '0;
            active   <= 1'b0;
            // NOTE: lane registers are cleared explicitly because outN must read 8'h00 after reset.
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            com_cnt  <= com_cnt_nxt;
            lane_ptr <= lane_ptr_nxt;
            slip_cnt <= slip_cnt_nxt;
            valid_q  <= valid_nxt;
            active   <= (state_nxt == ACTIVE);
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= lane_nxt[i];
            end
        end
    end

    assign out0       = lane_q[0];
    assign out1       = lane_q[1];
    assign out2       = lane_q[2];
    assign out3       = lane_q[3];
    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign valid_out3 = valid_q[3];

`ifdef PHY_RX_ERRCNT_EN
    logic err_inc;

    // Errors: a lock attempt aborted by a non-comma, or a comma seen off the byte boundary.
    assign err_inc = ((state == LOCKING) && boundary && !com_hit) ||
                     ((state == ACTIVE) && !boundary && com_hit);

    // Saturating error counter.
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_inc && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_rx_deser.sv
// Directed self-checking bench for phy_rx_deser (default COM=BC, IDLE=7C).
module tb_phy_rx_deser;
    import phy_rx_pkg::*;

    logic       clk_32f = 1'b0;
    logic       rst;
    logic       in_serial;
    logic [7:0] out0, out1, out2, out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       active;
`ifdef PHY_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_32f = ~clk_32f;

    phy_rx_deser dut (
        .clk_32f    (clk_32f),
        .rst        (rst),
        .in_serial  (in_serial),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .active     (active)
`ifdef PHY_RX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] valids();
        return {28'd0, valid_out3, valid_out2, valid_out1, valid_out0};
    endfunction

    // Drive one bit; return 1 time unit after the edge that sampled it.
    task automatic send_bit(input logic b);
        in_serial = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Send a byte MSB first; the valid vector must equal vexp right after bit vbit, else zero.
    task automatic send_byte(input logic [7:0] data, input int vbit, input logic [3:0] vexp);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[7-i]);
            check($sformatf("valid_%02h_b%0d", data, i), valids(),
                  (i == vbit) ? {28'd0, vexp} : 32'd0);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        check({tag, "_out0"}, 32'(out0), 32'(e0));
        check({tag, "_out1"}, 32'(out1), 32'(e1));
        check({tag, "_out2"}, 32'(out2), 32'(e2));
        check({tag, "_out3"}, 32'(out3), 32'(e3));
    endtask

    task automatic check_err(input string tag, input logic [7:0] exp);
`ifdef PHY_RX_ERRCNT_EN
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp));
`endif
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        in_serial = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        check_outs(tag, 8'h00, 8'h00, 8'h00, 8'h00);
        check({tag, "_valid"}, valids(), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(HUNT));
        check_err(tag, 8'h00);
        rst = 1'b0;
    endtask

    // Four commas: active must rise only after the 32nd bit.
    task automatic lock(input string tag);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC, 8, 4'b0000);
            check($sformatf("%s_active_c%0d", tag, k), 32'(active), (k == 3) ? 32'd1 : 32'd0);
        end
        check({tag, "_state"}, 32'(dut.state), 32'(ACTIVE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_serial = 1'b0;

        do_reset("rst0");
        lock("lock0");

        // Data on lanes 0..3, one strobe per byte, eight cycles apart.
        // The BB|CC seam contains 10111100 four bits off the boundary: one slip, one error.
        send_byte(8'hAA, 7, 4'b0001);
        send_byte(8'hBB, 7, 4'b0010);
        send_byte(8'hCC, 7, 4'b0100);
        send_byte(8'hDD, 7, 4'b1000);
        check_outs("data4", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        check_err("data4", 8'h01);

        // Comma resets lane_ptr; IDLE consumes lane 1 without a strobe.
        send_byte(8'hBC, 8, 4'b0000);
        send_byte(8'hFF, 7, 4'b0001);
        send_byte(8'h7C, 8, 4'b0000);
        send_byte(8'h00, 7, 4'b0100);
        check_outs("idle", 8'hFF, 8'hBB, 8'h00, 8'hDD);
        check("idle_active", 32'(active), 32'd1);

        // Lock abort: three commas then a non-comma at the boundary.
        do_reset("rst1");
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC, 8, 4'b0000);
            check($sformatf("abort_active_c%0d", k), 32'(active), 32'd0);
        end
        check("abort_state_locking", 32'(dut.state), 32'(LOCKING));
        send_byte(8'h55, 8, 4'b0000);
        check("abort_active", 32'(active), 32'd0);
        check("abort_state", 32'(dut.state), 32'(HUNT));
        check_err("abort", 8'h01);

        // One extra bit shifts every following comma one bit late. Each boundary then
        // sees {0, BC[7:1]} = 5E (data), and each comma completes off-boundary.
        do_reset("rst2");
        lock("lock2");
        send_bit(1'b0);
        check("slip_extra_valid", valids(), 32'd0);
        send_byte(8'hBC, 6, 4'b0001);
        check("slip1_active", 32'(active), 32'd1);
        send_byte(8'hBC, 6, 4'b0010);
        check("slip2_active", 32'(active), 32'd1);
        send_byte(8'hBC, 6, 4'b0100);
        check("slip3_active", 32'(active), 32'd0);
        check("slip3_state", 32'(dut.state), 32'(HUNT));
        check_outs("slip", 8'h5E, 8'h5E, 8'h5E, 8'h00);
        check_err("slip", 8'h03);

        // Reset in the middle of a byte while active.
        lock("lock3");
        send_byte(8'hAA, 7, 4'b0001);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        @(posedge clk_32f);
        #1;
        check_outs("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst_valid", valids(), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_state", 32'(dut.state), 32'(HUNT));
        check_err("midrst", 8'h00);
        rst = 1'b0;
        send_bit(1'b1);
        check("postrst_valid", valids(), 32'd0);
        check("postrst_active", 32'(active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
